xaddr_router: RTL and testbench

- Parametrised successor of the picoversat address decoder.
- Routes one master request to N slave ports, each with a base address and an offset-width window; lowest slave index wins on overlap.
- Adds per-slave ready handshake with wait states, a registered read-data return, a bus-timeout watchdog and a sticky trap status with captured faulting address.
- Sits between the picoversat controller data port and the memory, register file, debug-print and external slaves.

---
 rtl/xaddr_router_pkg.sv | 34 +++
 rtl/xaddr_router_match.sv | 42 ++++
 rtl/xaddr_router.sv | 182 ++++++++++++++++++
 tb/tb_xaddr_router.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xaddr_router_pkg.sv
// xaddr_router_pkg: FSM encoding, index-width helper and the default picoversat slave map.
// Build option XADDR_TIMEOUT_EN enables the bus-timeout watchdog in xaddr_router.
package xaddr_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } xr_state_t;

    // Default picoversat data-port map (13-bit address space).
    localparam logic [12:0] MEM_BASE  = 13'h0000;
    localparam logic [7:0]  MEM_OFFS  = 8'd11;
    localparam logic [12:0] REGF_BASE = 13'h0800;
    localparam logic [7:0]  REGF_OFFS = 8'd4;
    localparam logic [12:0] CPRT_BASE = 13'h0810;
    localparam logic [7:0]  CPRT_OFFS = 8'd1;
    localparam logic [12:0] EXT_BASE  = 13'h1000;
    localparam logic [7:0]  EXT_OFFS  = 8'd12;

    localparam logic [4*13-1:0] XR_DEFAULT_BASE_VEC = {EXT_BASE, CPRT_BASE, REGF_BASE, MEM_BASE};
    localparam logic [4*8-1:0]  XR_DEFAULT_OFFS_VEC = {EXT_OFFS, CPRT_OFFS, REGF_OFFS, MEM_OFFS};

`ifdef XADDR_TIMEOUT_EN
    localparam bit XR_TIMEOUT_EN = 1'b1;
`else
    localparam bit XR_TIMEOUT_EN = 1'b0;
`endif

    function automatic int unsigned xr_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xaddr_router_match.sv
// xaddr_match: per-slave base/offset-window hit vector with lowest-index priority select.
// Purely combinational so other bus masters can reuse the same decoder.
module xaddr_match
    import xaddr_router_pkg::*;
#(
    parameter int unsigned               ADDR_W   = 13,
    parameter int unsigned               N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0]   BASE_VEC = '0,
    parameter logic [N_SLV*8-1:0]        OFFS_VEC = {N_SLV{8'd4}},
    parameter int unsigned               IDX_W    = xr_idx_w(N_SLV)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_any_o,
    output logic [IDX_W-1:0]  idx_o
);

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [N_SLV-1:0] hit;

    for (genvar g = 0; g < N_SLV; g++) begin : g_win
        localparam int unsigned       OFFS = int'(OFFS_VEC[g*8 +: 8]);
        localparam logic [ADDR_W-1:0] BASE = BASE_VEC[g*ADDR_W +: ADDR_W];
        // One extra bit so an offset equal to ADDR_W yields an all-zero mask.
        localparam logic [ADDR_W:0]   LOW  = (ONE << OFFS) - ONE;
        localparam logic [ADDR_W-1:0] MASK = ~LOW[ADDR_W-1:0];

        assign hit[g] = ((addr_i & MASK) == BASE);
    end

    always_comb begin
        hit_any_o = 1'b0;
        idx_o     = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (hit[i] && !hit_any_o) begin
                hit_any_o = 1'b1;
                idx_o     = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/xaddr_router.sv
// xaddr_router: routes one master request to N_SLV windowed slaves with ready handshake,
// registered read data and sticky trap status. Watchdog built in with XADDR_TIMEOUT_EN.
module xaddr_router
    import xaddr_router_pkg::*;
#(
    parameter int unsigned               ADDR_W   = 13,
    parameter int unsigned               DATA_W   = 32,
    parameter int unsigned               N_SLV    = 4,
    parameter logic [N_SLV*ADDR_W-1:0]   BASE_VEC = '0,
    parameter logic [N_SLV*8-1:0]        OFFS_VEC = {N_SLV{8'd4}},
    parameter int unsigned               TMO_CYC  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         addr,
    input  logic                      sel,
    output logic                      ready,
    output logic [DATA_W-1:0]         data_to_rd,
    output logic [N_SLV-1:0]          slv_sel,
    input  logic [N_SLV-1:0]          slv_ready,
    input  logic [N_SLV*DATA_W-1:0]   slv_data_to_rd,
    output logic                      trap,
    output logic                      trap_pending,
    output logic [ADDR_W-1:0]         trap_addr,
    input  logic                      trap_clr
);

    localparam int unsigned IDX_W = xr_idx_w(N_SLV);

    if (N_SLV < 1 || N_SLV > 8) begin : g_bad_nslv
        $error("xaddr_router: N_SLV must be in 1..8");
    end
    if (TMO_CYC < 2) begin : g_bad_tmo
        $error("xaddr_router: TMO_CYC must be >= 2");
    end

    xr_state_t            state_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 ready_q;
    logic                 trap_q;
    logic [DATA_W-1:0]    data_q;
    logic                 trap_pending_q;
    logic [ADDR_W-1:0]    trap_addr_q;

    logic                 hit_any;
    logic [IDX_W-1:0]     match_idx;
    logic [IDX_W-1:0]     cur_idx;
    logic                 cur_rdy;
    logic [DATA_W-1:0]    rd_word;
    logic                 sel_en;
    logic                 tmo_hit;
    logic                 trap_d;

    xaddr_match #(
        .ADDR_W   (ADDR_W),
        .N_SLV    (N_SLV),
        .BASE_VEC (BASE_VEC),
        .OFFS_VEC (OFFS_VEC),
        .IDX_W    (IDX_W)
    ) u_match (
        .addr_i    (addr),
        .hit_any_o (hit_any),
        .idx_o     (match_idx)
    );

    // In BUSY the latched index steers everything; in IDLE the live decode does.
    assign cur_idx = (state_q == BUSY) ? idx_q : match_idx;
    assign sel_en  = ((state_q == IDLE) && sel && hit_any) || (state_q == BUSY);

    always_comb begin
        cur_rdy = 1'b0;
        rd_word = '0;
        slv_sel = '0;
        for (int unsigned i = 0; i < N_SLV; i++) begin
            if (IDX_W'(i) == cur_idx) begin
                cur_rdy    = slv_ready[i];
                rd_word    = slv_data_to_rd[i*DATA_W +: DATA_W];
                slv_sel[i] = sel_en;
            end
        end
    end

`ifdef XADDR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TMO_CYC + 1);

    logic [CNT_W-1:0] cnt_q;

    assign tmo_hit = (cnt_q == CNT_W'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        trap_d = 1'b0;
        if ((state_q == IDLE) && sel && !hit_any) begin
            trap_d = 1'b1;
        end
        if ((state_q == BUSY) && !cur_rdy && tmo_hit) begin
            trap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            ready_q        <= 1'b0;
            trap_q         <= 1'b0;
            data_q         <= '0;
            trap_pending_q <= 1'b0;
            trap_addr_q    <= '0;
        end else begin
            ready_q <= 1'b0;
            trap_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel) begin
                        if (!hit_any) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            trap_q  <= 1'b1;
                            data_q  <= '0;
                        end else if (cur_rdy) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                            data_q  <= rd_word;
                        end else begin
                            state_q <= BUSY;
                            idx_q   <= match_idx;
                        end
                    end
                end
                BUSY: begin
                    if (cur_rdy) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        data_q  <= rd_word;
                    end else if (tmo_hit) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        trap_q  <= 1'b1;
                        data_q  <= '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // A fresh trap overrides a simultaneous clear; otherwise the first fault is kept.
            if (trap_d) begin
                trap_pending_q <= 1'b1;
                if (!trap_pending_q || trap_clr) begin
                    trap_addr_q <= addr;
                end
            end else if (trap_clr) begin
                trap_pending_q <= 1'b0;
                trap_addr_q    <= '0;
            end
        end
    end

    assign ready        = ready_q;
    assign trap         = trap_q;
    assign data_to_rd   = data_q;
    assign trap_pending = trap_pending_q;
    assign trap_addr    = trap_addr_q;

endmodule

// File: tb/tb_xaddr_router.sv
// tb_xaddr_router: scoreboard bench for xaddr_router; the timeout scenario follows XADDR_TIMEOUT_EN.
module tb_xaddr_router;

    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned N_SLV   = 4;
    localparam int unsigned TMO_CYC = 16;
    // slave0 0x000/4, slave1 0x010/4, slave2 0x200/8, slave3 0x210/4 (shadowed by slave2)
    localparam logic [N_SLV*ADDR_W-1:0] BASES = {13'h210, 13'h200, 13'h010, 13'h000};
    localparam logic [N_SLV*8-1:0]      OFFS  = {8'd4, 8'd8, 8'd4, 8'd4};

    logic                    clk = 1'b0;
    logic                    rst;
    logic [ADDR_W-1:0]       addr;
    logic                    sel;
    logic                    ready;
    logic [DATA_W-1:0]       data_to_rd;
    logic [N_SLV-1:0]        slv_sel;
    logic [N_SLV-1:0]        slv_ready;
    logic [N_SLV*DATA_W-1:0] slv_data_to_rd;
    logic                    trap;
    logic                    trap_pending;
    logic [ADDR_W-1:0]       trap_addr;
    logic                    trap_clr;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              trap;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    assign slv_data_to_rd = {32'h3333_0003, 32'hCAFE_0002, 32'hDEAD_BEEF, 32'h0000_A0A0};

    xaddr_router #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .N_SLV    (N_SLV),
        .BASE_VEC (BASES),
        .OFFS_VEC (OFFS),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .sel            (sel),
        .ready          (ready),
        .data_to_rd     (data_to_rd),
        .slv_sel        (slv_sel),
        .slv_ready      (slv_ready),
        .slv_data_to_rd (slv_data_to_rd),
        .trap           (trap),
        .trap_pending   (trap_pending),
        .trap_addr      (trap_addr),
        .trap_clr       (trap_clr)
    );

    task automatic expect_resp(input logic [DATA_W-1:0] d, input logic t);
        exp_t e;
        e.data = d;
        e.trap = t;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        addr = a;
        sel  = 1'b1;
        #1;
    endtask

    // Waits (bounded) for ready, then pops the scoreboard and compares data and trap.
    task automatic wait_resp(input string name, input int max_cyc, output int cyc);
        exp_t e;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (ready === 1'b1) break;
            if (cyc >= max_cyc) begin
                $display("FAIL %s_ready: no ready after %0d cycles, required ready=1", name, cyc);
                n_err++;
                n_vec++;
                cyc = -1;
                return;
            end
        end
        if (sb.size() == 0) begin
            $display("FAIL %s_sb: ready with no expected response queued", name);
            n_err++;
            n_vec++;
            return;
        end
        e = sb.pop_front();
        n_vec++;
        if (data_to_rd !== e.data) begin
            $display("FAIL %s_data: got %h required %h", name, data_to_rd, e.data);
            n_err++;
        end
        n_vec++;
        if (trap !== e.trap) begin
            $display("FAIL %s_trap: got %b required %b", name, trap, e.trap);
            n_err++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sel       = 1'b0;
        trap_clr  = 1'b0;
        slv_ready = '0;
        addr      = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (ready !== 1'b0) begin $display("FAIL reset_ready: got %b required 0", ready); n_err++; end
        n_vec++; if (data_to_rd !== '0) begin $display("FAIL reset_data: got %h required 0", data_to_rd); n_err++; end
        n_vec++; if (slv_sel !== '0) begin $display("FAIL reset_slv_sel: got %b required 0000", slv_sel); n_err++; end
        n_vec++; if (trap !== 1'b0) begin $display("FAIL reset_trap: got %b required 0", trap); n_err++; end
        n_vec++; if (trap_pending !== 1'b0) begin $display("FAIL reset_pending: got %b required 0", trap_pending); n_err++; end
        n_vec++; if (trap_addr !== '0) begin $display("FAIL reset_trap_addr: got %h required 0", trap_addr); n_err++; end
        rst = 1'b0;
    endtask

    task automatic test_zero_wait();
        int cyc;
        slv_ready = 4'b0010;
        drive_req(13'h013);
        n_vec++; if (slv_sel !== 4'b0010) begin $display("FAIL zw_sel: got %b required 0010", slv_sel); n_err++; end
        n_vec++; if (ready !== 1'b0) begin $display("FAIL zw_early_ready: got %b required 0", ready); n_err++; end
        expect_resp(32'hDEAD_BEEF, 1'b0);
        wait_resp("zw_013", 4, cyc);
        sel = 1'b0;
        n_vec++; if (cyc != 1) begin $display("FAIL zw_latency: got %0d required 1", cyc); n_err++; end
        n_vec++; if (trap_pending !== 1'b0) begin $display("FAIL zw_pending: got %b required 0", trap_pending); n_err++; end
        @(negedge clk);
        n_vec++; if (ready !== 1'b0 || slv_sel !== '0) begin
            $display("FAIL zw_pulse: got ready=%b slv_sel=%b required 0/0000", ready, slv_sel); n_err++;
        end
        drive_req(13'h01F);
        n_vec++; if (slv_sel !== 4'b0010) begin $display("FAIL zw_top_sel: got %b required 0010", slv_sel); n_err++; end
        expect_resp(32'hDEAD_BEEF, 1'b0);
        wait_resp("zw_01F", 4, cyc);
        sel = 1'b0;
        slv_ready = '0;
    endtask

    task automatic test_wait_states();
        int cyc;
        slv_ready = '0;
        drive_req(13'h2A5);
        n_vec++; if (slv_sel !== 4'b0100) begin $display("FAIL ws_sel0: got %b required 0100", slv_sel); n_err++; end
        expect_resp(32'hCAFE_0002, 1'b0);
        @(negedge clk);
        n_vec++; if (slv_sel !== 4'b0100 || ready !== 1'b0) begin
            $display("FAIL ws_busy1: got sel=%b ready=%b required 0100/0", slv_sel, ready); n_err++;
        end
        slv_ready = 4'b1011;
        @(negedge clk);
        n_vec++; if (slv_sel !== 4'b0100 || ready !== 1'b0) begin
            $display("FAIL ws_foreign_ready: got sel=%b ready=%b required 0100/0", slv_sel, ready); n_err++;
        end
        slv_ready = '0;
        sel = 1'b0;
        @(negedge clk);
        n_vec++; if (slv_sel !== 4'b0100 || ready !== 1'b0) begin
            $display("FAIL ws_sel_dropped: got sel=%b ready=%b required 0100/0", slv_sel, ready); n_err++;
        end
        slv_ready = 4'b0100;
        wait_resp("ws", 4, cyc);
        slv_ready = '0;
        n_vec++; if (cyc != 1) begin $display("FAIL ws_latency: got %0d required 1", cyc); n_err++; end
    endtask

    task automatic test_priority();
        int cyc;
        slv_ready = 4'b1100;
        drive_req(13'h212);
        n_vec++; if (slv_sel !== 4'b0100) begin $display("FAIL prio_sel: got %b required 0100", slv_sel); n_err++; end
        expect_resp(32'hCAFE_0002, 1'b0);
        wait_resp("prio_212", 4, cyc);
        sel = 1'b0;
        slv_ready = 4'b0001;
        drive_req(13'h005);
        n_vec++; if (slv_sel !== 4'b0001) begin $display("FAIL prio_s0_sel: got %b required 0001", slv_sel); n_err++; end
        expect_resp(32'h0000_A0A0, 1'b0);
        wait_resp("prio_005", 4, cyc);
        sel = 1'b0;
        slv_ready = '0;
    endtask

    task automatic test_timeout();
        int cyc;
        slv_ready = '0;
        drive_req(13'h00A);
        n_vec++; if (slv_sel !== 4'b0001) begin $display("FAIL tmo_sel: got %b required 0001", slv_sel); n_err++; end
`ifdef XADDR_TIMEOUT_EN
        expect_resp('0, 1'b1);
        wait_resp("tmo", 40, cyc);
        sel = 1'b0;
        n_vec++; if (cyc != int'(TMO_CYC) + 1) begin $display("FAIL tmo_latency: got %0d required %0d", cyc, TMO_CYC + 1); n_err++; end
        n_vec++; if (trap_pending !== 1'b1) begin $display("FAIL tmo_pending: got %b required 1", trap_pending); n_err++; end
        n_vec++; if (trap_addr !== 13'h00A) begin $display("FAIL tmo_trap_addr: got %h required 00a", trap_addr); n_err++; end
`else
        begin
            int bad;
            bad = 0;
            repeat (100) begin
                @(negedge clk);
                if (ready !== 1'b0 || trap !== 1'b0 || slv_sel !== 4'b0001) bad++;
            end
            n_vec++; if (bad != 0) begin $display("FAIL notmo_hold: got %0d bad cycles required 0", bad); n_err++; end
        end
        slv_ready = 4'b0001;
        expect_resp(32'h0000_A0A0, 1'b0);
        wait_resp("notmo_done", 4, cyc);
        sel = 1'b0;
        slv_ready = '0;
        n_vec++; if (cyc != 1) begin $display("FAIL notmo_latency: got %0d required 1", cyc); n_err++; end
        n_vec++; if (trap_pending !== 1'b0) begin $display("FAIL notmo_pending: got %b required 0", trap_pending); n_err++; end
`endif
    endtask

    task automatic test_miss_trap();
        int cyc;
        pulse_clr();
        slv_ready = '1;
        drive_req(13'h1F00);
        n_vec++; if (slv_sel !== '0) begin $display("FAIL miss_sel: got %b required 0000", slv_sel); n_err++; end
        expect_resp('0, 1'b1);
        wait_resp("miss_1F00", 4, cyc);
        sel = 1'b0;
        n_vec++; if (cyc != 1) begin $display("FAIL miss_latency: got %0d required 1", cyc); n_err++; end
        n_vec++; if (trap_pending !== 1'b1) begin $display("FAIL miss_pending: got %b required 1", trap_pending); n_err++; end
        n_vec++; if (trap_addr !== 13'h1F00) begin $display("FAIL miss_trap_addr: got %h required 1f00", trap_addr); n_err++; end
        @(negedge clk);
        n_vec++; if (trap !== 1'b0 || trap_pending !== 1'b1) begin
            $display("FAIL miss_pulse: got trap=%b pending=%b required 0/1", trap, trap_pending); n_err++;
        end
        drive_req(13'h1E00);
        expect_resp('0, 1'b1);
        wait_resp("miss_1E00", 4, cyc);
        sel = 1'b0;
        n_vec++; if (trap_addr !== 13'h1F00) begin $display("FAIL miss_first_kept: got %h required 1f00", trap_addr); n_err++; end
        drive_req(13'h020);
        n_vec++; if (slv_sel !== '0) begin $display("FAIL miss_edge_sel: got %b required 0000", slv_sel); n_err++; end
        expect_resp('0, 1'b1);
        wait_resp("miss_020", 4, cyc);
        sel = 1'b0;
        pulse_clr();
        n_vec++; if (trap_pending !== 1'b0 || trap_addr !== '0) begin
            $display("FAIL miss_clr: got pending=%b addr=%h required 0/0000", trap_pending, trap_addr); n_err++;
        end
        drive_req(13'h1E00);
        expect_resp('0, 1'b1);
        wait_resp("miss_after_clr", 4, cyc);
        sel = 1'b0;
        n_vec++; if (trap_addr !== 13'h1E00) begin $display("FAIL miss_reload: got %h required 1e00", trap_addr); n_err++; end
        drive_req(13'h1D00);
        trap_clr = 1'b1;
        expect_resp('0, 1'b1);
        wait_resp("miss_clr_race", 4, cyc);
        trap_clr = 1'b0;
        sel = 1'b0;
        n_vec++; if (trap_pending !== 1'b1 || trap_addr !== 13'h1D00) begin
            $display("FAIL miss_clr_race: got pending=%b addr=%h required 1/1d00", trap_pending, trap_addr); n_err++;
        end
        slv_ready = '0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        slv_ready = '0;
        drive_req(13'h2A0);
        @(negedge clk);
        @(negedge clk);
        n_vec++; if (slv_sel !== 4'b0100) begin $display("FAIL rmid_busy: got %b required 0100", slv_sel); n_err++; end
        rst = 1'b1;
        sel = 1'b0;
        @(negedge clk);
        n_vec++; if (slv_sel !== '0 || ready !== 1'b0) begin
            $display("FAIL rmid_outputs: got sel=%b ready=%b required 0000/0", slv_sel, ready); n_err++;
        end
        n_vec++; if (trap_pending !== 1'b0 || trap_addr !== '0) begin
            $display("FAIL rmid_trap: got pending=%b addr=%h required 0/0000", trap_pending, trap_addr); n_err++;
        end
        rst = 1'b0;
        slv_ready = 4'b0010;
        drive_req(13'h018);
        expect_resp(32'hDEAD_BEEF, 1'b0);
        wait_resp("rmid_fresh", 4, cyc);
        sel = 1'b0;
        n_vec++; if (cyc != 1) begin $display("FAIL rmid_latency: got %0d required 1", cyc); n_err++; end
        slv_ready = '0;
    endtask

    task automatic test_back_to_back();
        int cyc;
        slv_ready = '1;
        drive_req(13'h003);
        expect_resp(32'h0000_A0A0, 1'b0);
        wait_resp("b2b_0", 4, cyc);
        addr = 13'h011;
        #1;
        n_vec++; if (slv_sel !== '0) begin $display("FAIL b2b_resp_sel: got %b required 0000", slv_sel); n_err++; end
        expect_resp(32'hDEAD_BEEF, 1'b0);
        wait_resp("b2b_1", 4, cyc);
        n_vec++; if (cyc != 2) begin $display("FAIL b2b_rate1: got %0d required 2", cyc); n_err++; end
        addr = 13'h2FF;
        expect_resp(32'hCAFE_0002, 1'b0);
        wait_resp("b2b_2", 4, cyc);
        sel = 1'b0;
        n_vec++; if (cyc != 2) begin $display("FAIL b2b_rate2: got %0d required 2", cyc); n_err++; end
        slv_ready = '0;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_priority();
        test_timeout();
        test_miss_trap();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            $display("FAIL sb_drain: %0d responses still expected, required 0", sb.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
